// File: rtl/ascon_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module   : ascon_fsm_if
//  Purpose  : Handshake and datapath-control bundle between the Ascon-128
//             sequencer (slave side) and its feeder/datapath (master side).
//  Revision : 1.0 - initial release
// ============================================================================
interface ascon_fsm_if;
  logic       i_start;
  logic       i_data_valid;
  logic       o_data_ready;
  logic       o_busy;
  logic       o_cipher_valid;
  logic       o_done;
  logic       o_sys_enable;
  logic       o_mux_select;
  logic       o_enable_xor_key_begin;
  logic       o_enable_xor_data_begin;
  logic       o_enable_xor_key_end;
  logic       o_enable_xor_lsb_end;
  logic       o_enable_cipher_reg;
  logic       o_enable_tag_reg;
  logic       o_enable_state_reg;
  logic [3:0] o_round;

  // Sequencer side
  modport slave (
    input  i_start, i_data_valid,
    output o_data_ready, o_busy, o_cipher_valid, o_done, o_sys_enable,
           o_mux_select, o_enable_xor_key_begin, o_enable_xor_data_begin,
           o_enable_xor_key_end, o_enable_xor_lsb_end, o_enable_cipher_reg,
           o_enable_tag_reg, o_enable_state_reg, o_round
  );

  // Feeder / datapath side
  modport master (
    output i_start, i_data_valid,
    input  o_data_ready, o_busy, o_cipher_valid, o_done, o_sys_enable,
           o_mux_select, o_enable_xor_key_begin, o_enable_xor_data_begin,
           o_enable_xor_key_end, o_enable_xor_lsb_end, o_enable_cipher_reg,
           o_enable_tag_reg, o_enable_state_reg, o_round
  );
endinterface
`default_nettype wire

// File: rtl/ascon_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : ascon_fsm
//  Purpose  : Control sequencer for the Ascon-128 round datapath. Steps one
//             message through init (p^12), AD blocks (p^6), PT blocks and
//             finalization (p^12) at one round per cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module ascon_fsm #(
  parameter int NUM_AD_BLOCKS = 1,
  parameter int NUM_PT_BLOCKS = 4
) (
  input  wire logic    clock,
  input  wire logic    reset,
  ascon_fsm_if.slave   bus
);

  localparam int c_MAX_BLK = (NUM_AD_BLOCKS > NUM_PT_BLOCKS) ? NUM_AD_BLOCKS : NUM_PT_BLOCKS;
  localparam int c_BLK_W   = $clog2(c_MAX_BLK + 1);
  localparam logic [c_BLK_W-1:0] c_LAST_AD = c_BLK_W'(NUM_AD_BLOCKS - 1);
  localparam logic [c_BLK_W-1:0] c_LAST_PT = c_BLK_W'(NUM_PT_BLOCKS - 1);
  localparam logic [c_BLK_W-1:0] c_BLK_ONE = c_BLK_W'(1);
  localparam logic [3:0] c_RND_LAST = 4'd11;
  localparam logic [3:0] c_RND_P6   = 4'd6;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    INIT       = 4'd1,
    WAIT_AD    = 4'd2,
    AD         = 4'd3,
    WAIT_PT    = 4'd4,
    PT         = 4'd5,
    WAIT_FINAL = 4'd6,
    FINAL      = 4'd7,
    DONE       = 4'd8
  } state_t;

  state_t             r_state;
  logic [3:0]         r_round;
  logic [c_BLK_W-1:0] r_blk;
  logic               r_cipher_valid;

  logic       w_data_ready, w_busy, w_done, w_sys_enable, w_mux_select;
  logic       w_key_begin, w_data_begin, w_key_end, w_lsb_end;
  logic       w_cipher_reg, w_tag_reg, w_state_reg;
  logic [3:0] w_round;
  logic       w_last_rnd;

  assign w_last_rnd = (r_round == c_RND_LAST);

  // Decode datapath controls from state, counters and the live handshake inputs
  always_comb begin
    w_data_ready = 1'b0;
    w_busy       = (r_state != IDLE);
    w_done       = 1'b0;
    w_sys_enable = 1'b1;
    w_mux_select = 1'b0;
    w_key_begin  = 1'b0;
    w_data_begin = 1'b0;
    w_key_end    = 1'b0;
    w_lsb_end    = 1'b0;
    w_cipher_reg = 1'b0;
    w_tag_reg    = 1'b0;
    w_state_reg  = 1'b0;
    w_round      = 4'd0;
    case (r_state)
      IDLE: w_sys_enable = ~bus.i_start;
      INIT: begin
        w_state_reg  = 1'b1;
        w_mux_select = (r_round != 4'd0);
        w_key_end    = w_last_rnd;
        w_round      = r_round;
      end
      WAIT_AD, WAIT_PT, WAIT_FINAL: begin
        w_data_ready = 1'b1;
        if (bus.i_data_valid) begin
          // The accepting cycle already executes the first round of the block
          w_data_begin = 1'b1;
          w_mux_select = 1'b1;
          w_state_reg  = 1'b1;
          w_round      = r_round;
          w_cipher_reg = (r_state != WAIT_AD);
          w_key_begin  = (r_state == WAIT_FINAL);
        end
      end
      AD: begin
        w_mux_select = 1'b1;
        w_state_reg  = 1'b1;
        w_round      = r_round;
        w_lsb_end    = w_last_rnd && (r_blk == c_LAST_AD);
      end
      PT: begin
        w_mux_select = 1'b1;
        w_state_reg  = 1'b1;
        w_round      = r_round;
      end
      FINAL: begin
        w_mux_select = 1'b1;
        w_state_reg  = 1'b1;
        w_round      = r_round;
        w_key_end    = w_last_rnd;
        w_tag_reg    = w_last_rnd;
      end
      DONE: w_done = 1'b1;
      default: w_sys_enable = 1'b1;
    endcase
    // Reset silences everything immediately, including the current cycle
    if (reset) begin
      w_data_ready = 1'b0;
      w_busy       = 1'b0;
      w_done       = 1'b0;
      w_sys_enable = 1'b0;
      w_mux_select = 1'b0;
      w_key_begin  = 1'b0;
      w_data_begin = 1'b0;
      w_key_end    = 1'b0;
      w_lsb_end    = 1'b0;
      w_cipher_reg = 1'b0;
      w_tag_reg    = 1'b0;
      w_state_reg  = 1'b0;
      w_round      = 4'd0;
    end
  end

  // State, round and block counters plus the delayed cipher-valid flag
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= IDLE;
      r_round        <= 4'd0;
      r_blk          <= '0;
      r_cipher_valid <= 1'b0;
    end else begin
      r_cipher_valid <= w_cipher_reg & w_sys_enable;
      case (r_state)
        IDLE: begin
          if (bus.i_start) begin
            r_state <= INIT;
            r_round <= 4'd0;
            r_blk   <= '0;
          end
        end
        INIT: begin
          if (w_last_rnd) begin
            r_state <= WAIT_AD;
            r_round <= c_RND_P6;
          end else begin
            r_round <= r_round + 4'd1;
          end
        end
        WAIT_AD: begin
          if (bus.i_data_valid) begin
            r_state <= AD;
            r_round <= r_round + 4'd1;
          end
        end
        AD: begin
          if (w_last_rnd) begin
            if (r_blk == c_LAST_AD) begin
              r_blk <= '0;
              // A single plaintext block is absorbed entirely by finalization
              if (c_LAST_PT == '0) begin
                r_state <= WAIT_FINAL;
                r_round <= 4'd0;
              end else begin
                r_state <= WAIT_PT;
                r_round <= c_RND_P6;
              end
            end else begin
              r_blk   <= r_blk + c_BLK_ONE;
              r_state <= WAIT_AD;
              r_round <= c_RND_P6;
            end
          end else begin
            r_round <= r_round + 4'd1;
          end
        end
        WAIT_PT: begin
          if (bus.i_data_valid) begin
            r_state <= PT;
            r_round <= r_round + 4'd1;
          end
        end
        PT: begin
          if (w_last_rnd) begin
            r_blk <= r_blk + c_BLK_ONE;
            if ((r_blk + c_BLK_ONE) == c_LAST_PT) begin
              r_state <= WAIT_FINAL;
              r_round <= 4'd0;
            end else begin
              r_state <= WAIT_PT;
              r_round <= c_RND_P6;
            end
          end else begin
            r_round <= r_round + 4'd1;
          end
        end
        WAIT_FINAL: begin
          if (bus.i_data_valid) begin
            r_state <= FINAL;
            r_round <= 4'd1;
          end
        end
        FINAL: begin
          if (w_last_rnd) begin
            r_state <= DONE;
            r_round <= 4'd0;
          end else begin
            r_round <= r_round + 4'd1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_round <= 4'd0;
          r_blk   <= '0;
        end
        default: begin
          r_state <= IDLE;
          r_round <= 4'd0;
          r_blk   <= '0;
        end
      endcase
    end
  end

  assign bus.o_data_ready            = w_data_ready;
  assign bus.o_busy                  = w_busy;
  assign bus.o_cipher_valid          = r_cipher_valid & ~reset;
  assign bus.o_done                  = w_done;
  assign bus.o_sys_enable            = w_sys_enable;
  assign bus.o_mux_select            = w_mux_select;
  assign bus.o_enable_xor_key_begin  = w_key_begin;
  assign bus.o_enable_xor_data_begin = w_data_begin;
  assign bus.o_enable_xor_key_end    = w_key_end;
  assign bus.o_enable_xor_lsb_end    = w_lsb_end;
  assign bus.o_enable_cipher_reg     = w_cipher_reg;
  assign bus.o_enable_tag_reg        = w_tag_reg;
  assign bus.o_enable_state_reg      = w_state_reg;
  assign bus.o_round                 = w_round;

endmodule
`default_nettype wire

// File: tb/tb_ascon_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ascon_fsm
//  Purpose  : Scoreboard bench for ascon_fsm (default 1/4 config and a 2/1
//             config). Expected event cycles are queued when a message starts
//             and consumed as the sequencer raises each output.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ascon_fsm;
  localparam int NA = 1;
  localparam int NP = 4;
  localparam logic [16:0] SYS_ONLY = 17'h01000;

  logic clock = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   t0 = -100;
  int   busy_lo = -1;
  int   busy_hi = -2;

  int         q_rdy[$], q_cv[$], q_lsb[$], q_kend[$], q_kbeg[$], q_tag[$], q_done[$];
  logic [4:0] q_rnd[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  ascon_fsm_if bus_a();
  ascon_fsm_if bus_b();

  ascon_fsm #(.NUM_AD_BLOCKS(NA), .NUM_PT_BLOCKS(NP)) u_dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  ascon_fsm #(.NUM_AD_BLOCKS(2), .NUM_PT_BLOCKS(1)) u_dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, act, exp);
    end
  endtask

  function automatic logic [16:0] outs_a();
    return {bus_a.o_data_ready, bus_a.o_busy, bus_a.o_cipher_valid, bus_a.o_done,
            bus_a.o_sys_enable, bus_a.o_mux_select, bus_a.o_enable_xor_key_begin,
            bus_a.o_enable_xor_data_begin, bus_a.o_enable_xor_key_end,
            bus_a.o_enable_xor_lsb_end, bus_a.o_enable_cipher_reg,
            bus_a.o_enable_tag_reg, bus_a.o_enable_state_reg, bus_a.o_round};
  endfunction

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  // Build the expected timeline of a message started at cycle t, with k
  // stall cycles inserted at the first WAIT_PT.
  task automatic push_run(input int t, input int k, output int t_done);
    int c;
    q_kend.push_back(t + 12);
    for (int r = 0; r < 12; r++) q_rnd.push_back({(r != 0), 4'(r)});
    c = t + 13;
    for (int i = 0; i < NA; i++) begin
      q_rdy.push_back(c);
      for (int r = 6; r < 12; r++) q_rnd.push_back({1'b1, 4'(r)});
      if (i == NA - 1) q_lsb.push_back(c + 5);
      c += 6;
    end
    for (int j = 0; j < NP - 1; j++) begin
      int st;
      st = (j == 0) ? k : 0;
      for (int s = 0; s <= st; s++) q_rdy.push_back(c + s);
      q_cv.push_back(c + st + 1);
      for (int r = 6; r < 12; r++) q_rnd.push_back({1'b1, 4'(r)});
      c += 6 + st;
    end
    q_rdy.push_back(c);
    q_kbeg.push_back(c);
    q_cv.push_back(c + 1);
    for (int r = 0; r < 12; r++) q_rnd.push_back({1'b1, 4'(r)});
    q_kend.push_back(c + 11);
    q_tag.push_back(c + 11);
    q_done.push_back(c + 12);
    busy_lo = t + 1;
    busy_hi = c + 12;
    t_done  = c + 12;
  endtask

  task automatic clear_q();
    q_rdy.delete(); q_cv.delete(); q_lsb.delete(); q_kend.delete();
    q_kbeg.delete(); q_tag.delete(); q_done.delete(); q_rnd.delete();
  endtask

  // Consume expected events as the default-config sequencer produces them
  always @(negedge clock) begin
    if (bus_a.o_data_ready) begin
      if (q_rdy.size() == 0) check("ready_extra", cyc, -1);
      else check("ready_cyc", cyc, q_rdy.pop_front());
    end
    if (bus_a.o_cipher_valid) begin
      if (q_cv.size() == 0) check("cv_extra", cyc, -1);
      else check("cv_cyc", cyc, q_cv.pop_front());
    end
    if (bus_a.o_enable_xor_lsb_end) begin
      if (q_lsb.size() == 0) check("lsb_extra", cyc, -1);
      else check("lsb_cyc", cyc, q_lsb.pop_front());
    end
    if (bus_a.o_enable_xor_key_end) begin
      if (q_kend.size() == 0) check("kend_extra", cyc, -1);
      else check("kend_cyc", cyc, q_kend.pop_front());
    end
    if (bus_a.o_enable_xor_key_begin) begin
      if (q_kbeg.size() == 0) check("kbeg_extra", cyc, -1);
      else check("kbeg_cyc", cyc, q_kbeg.pop_front());
    end
    if (bus_a.o_enable_tag_reg) begin
      if (q_tag.size() == 0) check("tag_extra", cyc, -1);
      else check("tag_cyc", cyc, q_tag.pop_front());
    end
    if (bus_a.o_done) begin
      if (q_done.size() == 0) check("done_extra", cyc, -1);
      else check("done_cyc", cyc, q_done.pop_front());
    end
    if (bus_a.o_enable_state_reg) begin
      if (q_rnd.size() == 0) check("round_extra", cyc, -1);
      else check("mux_round", {bus_a.o_mux_select, bus_a.o_round}, q_rnd.pop_front());
    end
    if (bus_a.o_data_ready && !bus_a.i_data_valid)
      check("stall_en", {bus_a.o_enable_state_reg, bus_a.o_enable_cipher_reg,
                         bus_a.o_enable_xor_data_begin, bus_a.o_mux_select, bus_a.o_round}, 0);
    check("busy", bus_a.o_busy, (cyc >= busy_lo && cyc <= busy_hi));
    check("sys_en", bus_a.o_sys_enable, !(reset || cyc == t0));
  end

  // One message on the default instance; abort_at > 0 asserts reset at that relative cycle
  task automatic run(input int k, input bit pulse, input int abort_at);
    int t_done;
    int rel;
    bit aborted;
    aborted = 1'b0;
    step();
    t0 = cyc;
    push_run(cyc, k, t_done);
    bus_a.i_start      = 1'b1;
    bus_a.i_data_valid = 1'b1;
    while (cyc < t_done + 2 && !aborted) begin
      step();
      rel = cyc - t0;
      bus_a.i_start      = pulse && (rel == 15 || rel == 40);
      bus_a.i_data_valid = !(rel >= 19 && rel < 19 + k);
      if (abort_at > 0 && rel == abort_at) begin
        reset = 1'b1;
        clear_q();
        busy_hi = cyc - 1;
        @(negedge clock);
        check("abort_out", outs_a(), 17'h0);
        step();
        reset = 1'b0;
        @(negedge clock);
        check("abort_idle", outs_a(), SYS_ONLY);
        aborted = 1'b1;
      end
    end
    bus_a.i_start = 1'b0;
    if (!aborted)
      check("q_left", q_rdy.size() + q_cv.size() + q_lsb.size() + q_kend.size() +
                      q_kbeg.size() + q_tag.size() + q_done.size() + q_rnd.size(), 0);
  endtask

  // Second configuration: two AD blocks, plaintext absorbed by finalization
  task automatic run_b();
    int tb;
    int rel;
    int nd;
    int nl;
    nd = 0;
    nl = 0;
    step();
    tb = cyc;
    bus_b.i_start      = 1'b1;
    bus_b.i_data_valid = 1'b1;
    for (int i = 0; i < 45; i++) begin
      @(negedge clock);
      rel = cyc - tb;
      if (rel == 0) check("b_sys_en", bus_b.o_sys_enable, 0);
      if (bus_b.o_enable_xor_lsb_end) begin
        nl++;
        check("b_lsb_cyc", rel, 24);
      end
      if (bus_b.o_enable_xor_key_begin)
        check("b_final_acc", {rel[15:0], 7'd0, bus_b.o_enable_xor_data_begin,
                              bus_b.o_enable_cipher_reg, bus_b.o_round},
              {16'd25, 7'd0, 1'b1, 1'b1, 4'd0});
      if (bus_b.o_done) begin
        nd++;
        check("b_done_cyc", rel, 37);
      end
      step();
      bus_b.i_start = 1'b0;
    end
    check("b_n_lsb", nl, 1);
    check("b_n_done", nd, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset              = 1'b1;
    bus_a.i_start      = 1'b0;
    bus_a.i_data_valid = 1'b0;
    bus_b.i_start      = 1'b0;
    bus_b.i_data_valid = 1'b0;
    repeat (3) step();
    @(negedge clock);
    check("rst_out", outs_a(), 17'h0);
    step();
    reset = 1'b0;
    @(negedge clock);
    check("rst_idle", outs_a(), SYS_ONLY);
    bus_a.i_data_valid = 1'b1;
    step();
    @(negedge clock);
    check("idle_valid_ignored", outs_a(), SYS_ONLY);

    run(0, 1'b0, 0);   // nominal message, DONE at +49
    run(3, 1'b0, 0);   // three-cycle stall at the first WAIT_PT, DONE at +52
    run(0, 1'b0, 30);  // reset during the second PT block
    run(0, 1'b0, 0);   // restart after abort, same timing
    run(0, 1'b1, 0);   // stray start pulses in AD and FINAL
    run_b();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
